pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipelined CPU. It decides each cycle whether the PC register advances, holds or takes the EX-stage redirect. It also decides whether each pipeline register advances, holds or is bubbled. It sequences the post-reset startup bubble, load-use stalls, branch/jump flushes and multi-cycle data-memory waits, with a watchdog and saturating performance counters.

---
 rtl/pipe_hazard_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the stall/flush controller (slave).
// CNT_W must match the controller's counter width.
interface pipe_hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_is_load;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ack;
    logic             pc_stop;
    logic             pc_redirect;
    logic             if_id_hold;
    logic             id_ex_hold;
    logic             ex_mem_hold;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_bubble;
    logic             mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_redirect, mem_req, mem_ack,
        input  pc_stop, pc_redirect, if_id_hold, id_ex_hold, ex_mem_hold,
               if_id_flush, id_ex_flush, mem_wb_bubble, mem_err, state,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_redirect, mem_req, mem_ack,
        output pc_stop, pc_redirect, if_id_hold, id_ex_hold, ex_mem_hold,
               if_id_flush, id_ex_flush, mem_wb_bubble, mem_err, state,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: boot bubble, load-use stall,
// EX redirect flush, data-memory wait freeze with watchdog, saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_hazard_if.slave hz
);
    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERR      = 2'd3
    } state_e;

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1)
                                                                : {WAIT_W{1'b1}};
    localparam bit WDOG_EN = (MEM_TIMEOUT != 0);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic lu_s, mem_block_s, freeze_s, run_s, boot_s;
    logic pc_stop_s, pc_redirect_s, if_id_hold_s, id_ex_hold_s, ex_mem_hold_s;
    logic if_id_flush_s, id_ex_flush_s, mem_wb_bubble_s;

    // Hazard detection on the raw operand/destination fields
    always_comb begin
        lu_s = hz.ex_is_load && (hz.ex_rd != 5'd0) &&
               ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
        mem_block_s = hz.mem_req && !hz.mem_ack;
    end

    // Next-state logic; freeze_s/run_s select which output decode applies this cycle
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        freeze_s   = 1'b0;
        run_s      = 1'b0;
        boot_s     = 1'b0;
        case (state_q)
            ST_BOOT: begin
                boot_s  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_block_s) begin
                    freeze_s   = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = {WAIT_W{1'b0}};
                end else begin
                    run_s = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!hz.mem_ack) begin
                    freeze_s = 1'b1;
                    // Saturate so a disabled watchdog never wraps the count
                    if (wait_cnt_q != {WAIT_W{1'b1}}) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                    if (WDOG_EN && (wait_cnt_q == WAIT_LAST)) begin
                        state_d   = ST_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end else begin
                    run_s   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
                freeze_s  = 1'b1;
                mem_err_d = 1'b1;
            end
            default: begin
                freeze_s = 1'b1;
                state_d  = ST_BOOT;
            end
        endcase
    end

    // Control decode; redirect outranks load-use so a squashed consumer never stalls
    always_comb begin
        pc_stop_s       = 1'b0;
        pc_redirect_s   = 1'b0;
        if_id_hold_s    = 1'b0;
        id_ex_hold_s    = 1'b0;
        ex_mem_hold_s   = 1'b0;
        if_id_flush_s   = 1'b0;
        id_ex_flush_s   = 1'b0;
        mem_wb_bubble_s = 1'b0;
        if (boot_s) begin
            pc_stop_s       = 1'b1;
            if_id_flush_s   = 1'b1;
            id_ex_flush_s   = 1'b1;
            mem_wb_bubble_s = 1'b1;
        end else if (freeze_s) begin
            pc_stop_s       = 1'b1;
            if_id_hold_s    = 1'b1;
            id_ex_hold_s    = 1'b1;
            ex_mem_hold_s   = 1'b1;
            mem_wb_bubble_s = 1'b1;
        end else if (run_s && hz.ex_redirect) begin
            pc_redirect_s = 1'b1;
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
        end else if (run_s && lu_s) begin
            pc_stop_s     = 1'b1;
            if_id_hold_s  = 1'b1;
            id_ex_flush_s = 1'b1;
        end else begin
            pc_stop_s = 1'b0;
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stop_s && ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) &&
            (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (pc_redirect_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            wait_cnt_q  <= {WAIT_W{1'b0}};
            mem_err_q   <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.pc_stop       = pc_stop_s;
    assign hz.pc_redirect   = pc_redirect_s;
    assign hz.if_id_hold    = if_id_hold_s;
    assign hz.id_ex_hold    = id_ex_hold_s;
    assign hz.ex_mem_hold   = ex_mem_hold_s;
    assign hz.if_id_flush   = if_id_flush_s;
    assign hz.id_ex_flush   = id_ex_flush_s;
    assign hz.mem_wb_bubble = mem_wb_bubble_s;
    assign hz.mem_err       = mem_err_q;
    assign hz.state         = state_q;
    assign hz.stall_cnt     = stall_cnt_q;
    assign hz.flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: dut_a uses the default parameters, dut_b uses
// MEM_TIMEOUT=4 and CNT_W=3; both see identical stimulus.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, mem_req, mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_if #(.CNT_W(32)) ifa ();
    pipe_hazard_if #(.CNT_W(3))  ifb ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa.slave));
    pipe_hazard_ctrl #(.MEM_TIMEOUT(4),  .CNT_W(3))  dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb.slave));

    assign ifa.id_rs1 = id_rs1;         assign ifb.id_rs1 = id_rs1;
    assign ifa.id_rs2 = id_rs2;         assign ifb.id_rs2 = id_rs2;
    assign ifa.id_use_rs1 = id_use_rs1; assign ifb.id_use_rs1 = id_use_rs1;
    assign ifa.id_use_rs2 = id_use_rs2; assign ifb.id_use_rs2 = id_use_rs2;
    assign ifa.ex_rd = ex_rd;           assign ifb.ex_rd = ex_rd;
    assign ifa.ex_is_load = ex_is_load; assign ifb.ex_is_load = ex_is_load;
    assign ifa.ex_redirect = ex_redirect; assign ifb.ex_redirect = ex_redirect;
    assign ifa.mem_req = mem_req;       assign ifb.mem_req = mem_req;
    assign ifa.mem_ack = mem_ack;       assign ifb.mem_ack = mem_ack;

    // {pc_stop, pc_redirect, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, mem_wb_bubble, mem_err}
    wire [8:0] ctl_a = {ifa.pc_stop, ifa.pc_redirect, ifa.if_id_hold, ifa.id_ex_hold, ifa.ex_mem_hold,
                        ifa.if_id_flush, ifa.id_ex_flush, ifa.mem_wb_bubble, ifa.mem_err};
    wire [8:0] ctl_b = {ifb.pc_stop, ifb.pc_redirect, ifb.if_id_hold, ifb.id_ex_hold, ifb.ex_mem_hold,
                        ifb.if_id_flush, ifb.id_ex_flush, ifb.mem_wb_bubble, ifb.mem_err};

    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_BOOT = 9'b100001110;
    localparam logic [8:0] C_LU   = 9'b101000100;
    localparam logic [8:0] C_RD   = 9'b010001100;
    localparam logic [8:0] C_FRZ  = 9'b101110010;
    localparam logic [8:0] C_ERR  = 9'b101110011;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [4:0]  rd;
        logic        ld, redir, req, ack;
        logic [8:0]  ctl;
        logic [1:0]  st;
        logic [31:0] stall, flush;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic [4:0] rd, input logic ld,
                                input logic redir, input logic req, input logic ack,
                                input logic [8:0] ctl, input logic [1:0] st,
                                input logic [31:0] stall, input logic [31:0] flush);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.ld = ld;
        v.redir = redir; v.req = req; v.ack = ack; v.ctl = ctl; v.st = st;
        v.stall = stall; v.flush = flush;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_is_load = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        vecs[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_BOOT, 2'd0, 32'd0, 32'd0);
        vecs[1]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd1, 32'd0, 32'd0);
        vecs[2]  = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   2'd1, 32'd0, 32'd0);
        vecs[3]  = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'd1, 32'd1, 32'd0);
        vecs[4]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'd1, 32'd1, 32'd0);
        vecs[5]  = mk(5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE, 2'd1, 32'd1, 32'd0);
        vecs[6]  = mk(5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   2'd1, 32'd1, 32'd0);
        vecs[7]  = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_RD,   2'd1, 32'd2, 32'd0);
        vecs[8]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ,  2'd1, 32'd2, 32'd1);
        vecs[9]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ,  2'd2, 32'd3, 32'd1);
        vecs[10] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ,  2'd2, 32'd4, 32'd1);
        vecs[11] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_RD,   2'd2, 32'd5, 32'd1);
        vecs[12] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd1, 32'd5, 32'd2);
        vecs[13] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE, 2'd1, 32'd5, 32'd2);
        vecs[14] = mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 2'd1, 32'd5, 32'd2);

        do_reset();

        // Table: one vector per cycle, state carried from vector to vector
        for (int i = 0; i < 15; i++) begin
            rst_n       = 1'b1;
            id_rs1      = vecs[i].rs1;
            id_rs2      = vecs[i].rs2;
            id_use_rs1  = vecs[i].u1;
            id_use_rs2  = vecs[i].u2;
            ex_rd       = vecs[i].rd;
            ex_is_load  = vecs[i].ld;
            ex_redirect = vecs[i].redir;
            mem_req     = vecs[i].req;
            mem_ack     = vecs[i].ack;
            #1;
            chk($sformatf("vec%0d ctl_a", i), {23'd0, ctl_a}, {23'd0, vecs[i].ctl});
            chk($sformatf("vec%0d state_a", i), {30'd0, ifa.state}, {30'd0, vecs[i].st});
            chk($sformatf("vec%0d stall_a", i), ifa.stall_cnt, vecs[i].stall);
            chk($sformatf("vec%0d flush_a", i), ifa.flush_cnt, vecs[i].flush);
            chk($sformatf("vec%0d ctl_b", i), {23'd0, ctl_b}, {23'd0, vecs[i].ctl});
            chk($sformatf("vec%0d state_b", i), {30'd0, ifb.state}, {30'd0, vecs[i].st});
            tick();
        end

        // Watchdog: b times out after 4 wait cycles, a after 16
        do_reset();
        rst_n = 1'b1;
        #1;
        chk("wd boot state_a", {30'd0, ifa.state}, 32'd0);
        tick();
        mem_req = 1'b1;
        #1;
        chk("wd run state_a", {30'd0, ifa.state}, 32'd1);
        chk("wd run ctl_a", {23'd0, ctl_a}, {23'd0, C_FRZ});
        tick();
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk($sformatf("wd k%0d state_a", k), {30'd0, ifa.state}, 32'd2);
            chk($sformatf("wd k%0d state_b", k), {30'd0, ifb.state}, (k <= 4) ? 32'd2 : 32'd3);
            chk($sformatf("wd k%0d err_b", k), {31'd0, ifb.mem_err}, (k <= 4) ? 32'd0 : 32'd1);
            tick();
        end
        #1;
        chk("wd end state_a", {30'd0, ifa.state}, 32'd3);
        chk("wd end ctl_a", {23'd0, ctl_a}, {23'd0, C_ERR});
        mem_ack = 1'b1;
        #1;
        chk("wd ack ctl_a", {23'd0, ctl_a}, {23'd0, C_ERR});
        chk("wd ack ctl_b", {23'd0, ctl_b}, {23'd0, C_ERR});
        tick();
        chk("wd sticky state_a", {30'd0, ifa.state}, 32'd3);
        chk("wd stall_a", ifa.stall_cnt, 32'd17);
        chk("wd stall_b", {29'd0, ifb.stall_cnt}, 32'd5);
        rst_n = 1'b0;
        tick();
        chk("wd rst state_a", {30'd0, ifa.state}, 32'd0);
        chk("wd rst state_b", {30'd0, ifb.state}, 32'd0);
        chk("wd rst err_a", {31'd0, ifa.mem_err}, 32'd0);
        chk("wd rst stall_a", ifa.stall_cnt, 32'd0);
        chk("wd rst ctl_a", {23'd0, ctl_a}, {23'd0, C_BOOT});

        // Saturation: 9 back-to-back load-use stalls
        clear_inputs();
        rst_n = 1'b1;
        tick();
        ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk($sformatf("sat k%0d ctl_b", k), {23'd0, ctl_b}, {23'd0, C_LU});
            tick();
        end
        clear_inputs();
        #1;
        chk("sat stall_b", {29'd0, ifb.stall_cnt}, 32'd7);
        chk("sat stall_a", ifa.stall_cnt, 32'd9);
        chk("sat flush_b", {29'd0, ifb.flush_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
